// File: rtl/switch_mcu_fetch.sv
// Instruction fetch stage: requests instruction words from memory at the PC, holds each
// word for the decoder and applies ALU/branch redirects, including ones that arrive mid-request.
module switch_mcu_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0004,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        in_clk,
  input  logic        in_rst,
  output logic        out_imem_req,
  output logic [31:0] out_imem_addr,
  input  logic        in_imem_ack,
  input  logic [31:0] in_imem_rdata,
  input  logic        in_redirect_vld,
  input  logic [31:0] in_redirect_pc,
  output logic [31:0] out_inst,
  output logic        out_inst_vld,
  input  logic        in_inst_rdy,
  output logic [31:0] out_pc,
  output logic        out_fetch_err,
  output logic        out_misalign,
  output logic [15:0] out_fetch_cnt
);

  localparam int unsigned TO_W = 8;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  state_t          state, state_d;
  logic [31:0]     pc, pc_d;
  logic [31:0]     pend_pc, pend_pc_d;
  logic            pend_vld, pend_vld_d;
  logic [TO_W-1:0] to_cnt, to_cnt_d;
  logic            req_d, vld_d, err_d, mis_d;
  logic [31:0]     inst_d, opc_d;
  logic [15:0]     cnt_d;
  logic [31:0]     tgt;

  assign out_imem_addr = pc;
  assign tgt = {in_redirect_pc[31:2], 2'b00};

  // Next-state and datapath; a redirect always wins over ack and decoder ready
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    pend_pc_d  = pend_pc;
    pend_vld_d = pend_vld;
    to_cnt_d   = to_cnt;
    inst_d     = out_inst;
    vld_d      = out_inst_vld;
    opc_d      = out_pc;
    err_d      = 1'b0;
    mis_d      = out_misalign;
    cnt_d      = out_fetch_cnt;

    if (in_redirect_vld && (in_redirect_pc[1:0] != 2'b00)) mis_d = 1'b1;

    unique case (state)
      S_IDLE: begin
        state_d = S_REQ;
        if (in_redirect_vld) pc_d = tgt;
      end
      S_REQ: begin
        if (in_imem_ack) begin
          to_cnt_d = '0;
          if (in_redirect_vld) begin
            pc_d       = tgt;
            pend_vld_d = 1'b0;
          end else if (pend_vld) begin
            pc_d       = pend_pc;
            pend_vld_d = 1'b0;
          end else begin
            inst_d  = in_imem_rdata;
            opc_d   = pc;
            vld_d   = 1'b1;
            state_d = S_HOLD;
          end
        end else begin
          // Redirect during an outstanding request is deferred until the ack returns
          if (in_redirect_vld) begin
            pend_vld_d = 1'b1;
            pend_pc_d  = tgt;
          end
          if (to_cnt == TO_LAST) begin
            err_d    = 1'b1;
            to_cnt_d = '0;
          end else begin
            to_cnt_d = to_cnt + TO_W'(1);
          end
        end
      end
      S_HOLD: begin
        if (in_redirect_vld) begin
          pc_d    = tgt;
          inst_d  = NOP_INST;
          vld_d   = 1'b0;
          state_d = S_REQ;
        end else if (in_inst_rdy) begin
          pc_d    = pc + 32'd4;
          inst_d  = NOP_INST;
          vld_d   = 1'b0;
          cnt_d   = out_fetch_cnt + 16'd1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_d = (state_d == S_REQ);
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state         <= S_IDLE;
      pc            <= RESET_PC;
      pend_pc       <= '0;
      pend_vld      <= 1'b0;
      to_cnt        <= '0;
      out_imem_req  <= 1'b0;
      out_inst      <= NOP_INST;
      out_inst_vld  <= 1'b0;
      out_pc        <= RESET_PC;
      out_fetch_err <= 1'b0;
      out_misalign  <= 1'b0;
      out_fetch_cnt <= '0;
    end else begin
      state         <= state_d;
      pc            <= pc_d;
      pend_pc       <= pend_pc_d;
      pend_vld      <= pend_vld_d;
      to_cnt        <= to_cnt_d;
      out_imem_req  <= req_d;
      out_inst      <= inst_d;
      out_inst_vld  <= vld_d;
      out_pc        <= opc_d;
      out_fetch_err <= err_d;
      out_misalign  <= mis_d;
      out_fetch_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_switch_mcu_fetch.sv
// Directed bench for switch_mcu_fetch: inputs change and outputs are sampled on the falling edge.
module tb_switch_mcu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_vld;
  logic [31:0] redirect_pc;
  logic [31:0] inst;
  logic        inst_vld;
  logic        inst_rdy;
  logic [31:0] pc;
  logic        fetch_err;
  logic        misalign;
  logic [15:0] fetch_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  switch_mcu_fetch dut (
    .in_clk          (clk),
    .in_rst          (rst),
    .out_imem_req    (imem_req),
    .out_imem_addr   (imem_addr),
    .in_imem_ack     (imem_ack),
    .in_imem_rdata   (imem_rdata),
    .in_redirect_vld (redirect_vld),
    .in_redirect_pc  (redirect_pc),
    .out_inst        (inst),
    .out_inst_vld    (inst_vld),
    .in_inst_rdy     (inst_rdy),
    .out_pc          (pc),
    .out_fetch_err   (fetch_err),
    .out_misalign    (misalign),
    .out_fetch_cnt   (fetch_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " req"},  32'(imem_req),  32'd0);
    check({tag, " addr"}, imem_addr,      32'h4);
    check({tag, " inst"}, inst,           32'h13);
    check({tag, " vld"},  32'(inst_vld),  32'd0);
    check({tag, " pc"},   pc,             32'h4);
    check({tag, " err"},  32'(fetch_err), 32'd0);
    check({tag, " mis"},  32'(misalign),  32'd0);
    check({tag, " cnt"},  32'(fetch_cnt), 32'd0);
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    redirect_vld = 1'b0; redirect_pc = '0; inst_rdy = 1'b0;
    @(negedge clk);
    check_reset("rst");
    @(negedge clk);
    rst = 1'b0;

    // Idle lasts one cycle, then first request at RESET_PC
    tick();
    check("first req", 32'(imem_req), 32'd1);
    check("first addr", imem_addr, 32'h4);
    imem_ack = 1'b1; imem_rdata = 32'hAAAAA0B7; inst_rdy = 1'b1;
    tick();
    check("fetch vld", 32'(inst_vld), 32'd1);
    check("fetch inst", inst, 32'hAAAAA0B7);
    check("fetch pc", pc, 32'h4);
    check("hold no req", 32'(imem_req), 32'd0);
    imem_ack = 1'b0;
    tick();
    check("xfer req", 32'(imem_req), 32'd1);
    check("xfer addr", imem_addr, 32'h8);
    check("xfer cnt", 32'(fetch_cnt), 32'd1);
    check("xfer vld", 32'(inst_vld), 32'd0);
    check("xfer nop", inst, 32'h13);

    // Decoder stall: held word at 0x8 stays put for 5 cycles
    imem_ack = 1'b1; imem_rdata = 32'h00100093; inst_rdy = 1'b0;
    tick();
    imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall inst", inst, 32'h00100093);
      check("stall pc", pc, 32'h8);
      check("stall req", 32'(imem_req), 32'd0);
      check("stall cnt", 32'(fetch_cnt), 32'd1);
    end
    inst_rdy = 1'b1;
    tick();
    check("stall next addr", imem_addr, 32'hC);
    check("stall next cnt", 32'(fetch_cnt), 32'd2);
    inst_rdy = 1'b0;

    // Redirect to 0x100 while the ack at 0xC is stalled; late ack data is dropped
    redirect_vld = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_vld = 1'b0;
    check("pend addr", imem_addr, 32'hC);
    tick();
    tick();
    check("pend addr2", imem_addr, 32'hC);
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    tick();
    check("pend drop vld", 32'(inst_vld), 32'd0);
    check("pend new addr", imem_addr, 32'h100);
    check("pend req", 32'(imem_req), 32'd1);
    imem_rdata = 32'h12345678;
    tick();
    imem_ack = 1'b0;
    check("redir inst", inst, 32'h12345678);
    check("redir pc", pc, 32'h100);
    check("redir vld", 32'(inst_vld), 32'd1);

    // Misaligned redirect in hold with rdy: no transfer, aligned target
    redirect_vld = 1'b1; redirect_pc = 32'h203; inst_rdy = 1'b1;
    tick();
    redirect_vld = 1'b0; inst_rdy = 1'b0;
    check("hold redir cnt", 32'(fetch_cnt), 32'd2);
    check("hold redir vld", 32'(inst_vld), 32'd0);
    check("hold redir addr", imem_addr, 32'h200);
    check("hold redir mis", 32'(misalign), 32'd1);
    check("hold redir nop", inst, 32'h13);

    // Ack timeout: err pulses in the 16th request cycle (now in cycle 1)
    for (int i = 2; i <= 15; i++) begin
      tick();
      check("to quiet", 32'(fetch_err), 32'd0);
    end
    tick();
    check("to err", 32'(fetch_err), 32'd1);
    check("to req", 32'(imem_req), 32'd1);
    check("to addr", imem_addr, 32'h200);
    tick();
    check("to pulse", 32'(fetch_err), 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h00000297; inst_rdy = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("to fetch inst", inst, 32'h00000297);
    check("to fetch pc", pc, 32'h200);
    tick();
    inst_rdy = 1'b0;
    check("to next addr", imem_addr, 32'h204);
    check("to next cnt", 32'(fetch_cnt), 32'd3);

    // Newer pending redirect overwrites the older one
    redirect_vld = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_pc = 32'h400;
    tick();
    redirect_vld = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h11111111;
    tick();
    check("ovw addr", imem_addr, 32'h400);
    check("ovw vld", 32'(inst_vld), 32'd0);
    // Redirect with same-cycle ack: data dropped, new address next cycle
    redirect_vld = 1'b1; redirect_pc = 32'h500;
    tick();
    redirect_vld = 1'b0; imem_ack = 1'b0;
    check("ack redir addr", imem_addr, 32'h500);
    check("ack redir vld", 32'(inst_vld), 32'd0);
    check("ack redir req", 32'(imem_req), 32'd1);

    // Asynchronous reset mid-request, then restart at RESET_PC
    #1 rst = 1'b1;
    #1 check_reset("async rst");
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("restart req", 32'(imem_req), 32'd1);
    check("restart addr", imem_addr, 32'h4);
    check("restart vld", 32'(inst_vld), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
